// File: rtl/bus_port_fifo_pkg.sv
// Shared constants for the bus port FIFO: default geometry, drop counter width
// and bit positions inside err_flags.
package bus_pkg;
   localparam int DEF_WIDTH  = 16;
   localparam int DEF_DEPTH  = 8;
   localparam int DROP_CNT_W = 8;

   localparam int ERR_TX_OVF = 0;
   localparam int ERR_TX_UDF = 1;
   localparam int ERR_RX_OVF = 2;
   localparam int ERR_RX_UDF = 3;
   localparam int ERR_W      = 4;
endpackage

// File: rtl/bus_port_fifo_if.sv
// Device-side and arbiter-side signals of one bus port. The FIFO is the slave;
// the device plus the bus arbiter together form the master.
interface bus_port_fifo_if
   import bus_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH
);
   logic                  dev_wr;
   logic [WIDTH-1:0]      dev_wdata;
   logic                  tx_full;
   logic                  pndng;
   logic [WIDTH-1:0]      D_pop;
   logic                  pop;
   logic                  push;
   logic [WIDTH-1:0]      D_push;
   logic                  rx_valid;
   logic [WIDTH-1:0]      dev_rdata;
   logic                  dev_rd;
   logic                  rx_full;
   logic [ERR_W-1:0]      err_flags;
   logic [DROP_CNT_W-1:0] rx_drop_cnt;

   // Strobes (dev_wr, pop, push, dev_rd) are single-cycle requests sampled at
   // the rising edge; pndng/rx_valid qualify the show-ahead heads D_pop/dev_rdata.
   modport slave (
      input  dev_wr, dev_wdata, pop, push, D_push, dev_rd,
      output tx_full, pndng, D_pop, rx_valid, dev_rdata, rx_full,
             err_flags, rx_drop_cnt
   );

   modport master (
      output dev_wr, dev_wdata, pop, push, D_push, dev_rd,
      input  tx_full, pndng, D_pop, rx_valid, dev_rdata, rx_full,
             err_flags, rx_drop_cnt
   );
endinterface

// File: rtl/bus_sync_fifo.sv
// Show-ahead synchronous FIFO with full/empty status and single-cycle
// overflow/underflow pulses for illegal write/read attempts.
module bus_sync_fifo #(
   parameter int W = 16,
   parameter int D = 8
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         i_wr,
   input  logic [W-1:0] i_wdata,
   input  logic         i_rd,
   output logic [W-1:0] o_rdata,
   output logic         o_not_empty,
   output logic         o_full,
   output logic         o_ovf,
   output logic         o_udf
);
   localparam int PTR_W = $clog2(D);
   localparam int CNT_W = PTR_W + 1;

   logic [W-1:0]     r_mem [D];
   logic [PTR_W-1:0] r_wr_ptr;
   logic [PTR_W-1:0] r_rd_ptr;
   logic [CNT_W-1:0] r_count;

   logic w_empty;
   logic w_full;
   logic w_do_rd;
   logic w_do_wr;

   assign w_empty = (r_count == '0);
   assign w_full  = (r_count == CNT_W'(D));
   assign w_do_rd = i_rd && !w_empty;
   // A full queue still takes a write when the head leaves in the same cycle.
   assign w_do_wr = i_wr && (!w_full || w_do_rd);

   assign o_ovf       = i_wr && w_full && !i_rd;
   assign o_udf       = i_rd && w_empty;
   assign o_full      = w_full;
   assign o_not_empty = !w_empty;
   assign o_rdata     = w_empty ? '0 : r_mem[r_rd_ptr];

   always_ff @(posedge clk) begin
      if (!reset) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_do_wr) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
         if (w_do_rd) r_rd_ptr <= r_rd_ptr + PTR_W'(1);
         case ({w_do_wr, w_do_rd})
            2'b10:   r_count <= r_count + CNT_W'(1);
            2'b01:   r_count <= r_count - CNT_W'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset && w_do_wr) r_mem[r_wr_ptr] <= i_wdata;
   end
endmodule

// File: rtl/bus_port_fifo.sv
// Bus port: a TX queue from the device to the bus arbiter and an independent
// RX queue back, with sticky error flags and a saturating RX drop counter.
module bus_port_fifo
   import bus_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH,
   parameter int DEPTH = DEF_DEPTH
) (
   input  logic            clk,
   input  logic            reset,
   bus_port_fifo_if.slave  bus
);
   logic w_tx_ovf;
   logic w_tx_udf;
   logic w_rx_ovf;
   logic w_rx_udf;

   logic [ERR_W-1:0]      r_err_flags;
   logic [DROP_CNT_W-1:0] r_drop_cnt;
   logic [ERR_W-1:0]      w_err_set;

   bus_sync_fifo #(.W(WIDTH), .D(DEPTH)) u_tx_fifo (
      .clk         (clk),
      .reset       (reset),
      .i_wr        (bus.dev_wr),
      .i_wdata     (bus.dev_wdata),
      .i_rd        (bus.pop),
      .o_rdata     (bus.D_pop),
      .o_not_empty (bus.pndng),
      .o_full      (bus.tx_full),
      .o_ovf       (w_tx_ovf),
      .o_udf       (w_tx_udf)
   );

   bus_sync_fifo #(.W(WIDTH), .D(DEPTH)) u_rx_fifo (
      .clk         (clk),
      .reset       (reset),
      .i_wr        (bus.push),
      .i_wdata     (bus.D_push),
      .i_rd        (bus.dev_rd),
      .o_rdata     (bus.dev_rdata),
      .o_not_empty (bus.rx_valid),
      .o_full      (bus.rx_full),
      .o_ovf       (w_rx_ovf),
      .o_udf       (w_rx_udf)
   );

   always_comb begin
      w_err_set             = '0;
      w_err_set[ERR_TX_OVF] = w_tx_ovf;
      w_err_set[ERR_TX_UDF] = w_tx_udf;
      w_err_set[ERR_RX_OVF] = w_rx_ovf;
      w_err_set[ERR_RX_UDF] = w_rx_udf;
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         r_err_flags <= '0;
         r_drop_cnt  <= '0;
      end else begin
         r_err_flags <= r_err_flags | w_err_set;
         if (w_rx_ovf && (r_drop_cnt != '1)) r_drop_cnt <= r_drop_cnt + DROP_CNT_W'(1);
      end
   end

   assign bus.err_flags   = r_err_flags;
   assign bus.rx_drop_cnt = r_drop_cnt;
endmodule

// File: tb/tb_bus_port_fifo.sv
// Directed bench for bus_port_fifo: ordering, full/empty boundaries, sticky
// errors, drop counter saturation and reset in the middle of traffic.
module tb_bus_port_fifo;
   logic clk;
   logic reset;
   int   n_total;
   int   n_bad;
   logic [15:0] exp_q[$];

   bus_port_fifo_if u_if ();

   bus_port_fifo u_dut (
      .clk   (clk),
      .reset (reset),
      .bus   (u_if)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got=0x%0h exp=0x%0h", tag, got, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      u_if.dev_wr    = 1'b0;
      u_if.dev_wdata = '0;
      u_if.pop       = 1'b0;
      u_if.push      = 1'b0;
      u_if.D_push    = '0;
      u_if.dev_rd    = 1'b0;
   endtask

   task automatic do_reset();
      reset = 1'b0;
      cyc();
      cyc();
      reset = 1'b1;
   endtask

   task automatic chk_empty(input string tag);
      chk({tag, "_pndng"},   32'(u_if.pndng),       32'd0);
      chk({tag, "_rxv"},     32'(u_if.rx_valid),    32'd0);
      chk({tag, "_txfull"},  32'(u_if.tx_full),     32'd0);
      chk({tag, "_rxfull"},  32'(u_if.rx_full),     32'd0);
      chk({tag, "_dpop"},    32'(u_if.D_pop),       32'd0);
      chk({tag, "_rdata"},   32'(u_if.dev_rdata),   32'd0);
      chk({tag, "_err"},     32'(u_if.err_flags),   32'd0);
      chk({tag, "_drop"},    32'(u_if.rx_drop_cnt), 32'd0);
   endtask

   initial begin
      logic [15:0] v;
      n_total = 0;
      n_bad   = 0;
      idle();
      do_reset();
      chk_empty("rst");

      // three writes, show-ahead head, in-order pops
      u_if.dev_wr = 1'b1; u_if.dev_wdata = 16'h0A01;
      cyc();
      chk("wr1_pndng", 32'(u_if.pndng), 32'd1);
      chk("wr1_dpop",  32'(u_if.D_pop), 32'h0A01);
      u_if.dev_wdata = 16'h0A02; cyc();
      u_if.dev_wdata = 16'h0A03; cyc();
      idle();
      exp_q = '{16'h0A01, 16'h0A02, 16'h0A03};
      while (exp_q.size() > 0) begin
         v = exp_q.pop_front();
         chk("pop_order", 32'(u_if.D_pop), 32'(v));
         u_if.pop = 1'b1; cyc(); u_if.pop = 1'b0;
      end
      chk("drained_pndng", 32'(u_if.pndng), 32'd0);
      chk("drained_dpop",  32'(u_if.D_pop), 32'd0);
      chk("drained_err",   32'(u_if.err_flags), 32'd0);

      // nine writes: eighth fills, ninth dropped
      for (int i = 0; i < 9; i++) begin
         u_if.dev_wr = 1'b1; u_if.dev_wdata = 16'h0100 + 16'(i);
         cyc();
         if (i == 6) chk("tx_not_full_7", 32'(u_if.tx_full), 32'd0);
         if (i == 7) chk("tx_full_8",     32'(u_if.tx_full), 32'd1);
      end
      idle();
      chk("ovf_full",  32'(u_if.tx_full),   32'd1);
      chk("ovf_err",   32'(u_if.err_flags), 32'b0001);
      chk("ovf_head",  32'(u_if.D_pop),     32'h0100);

      // write + pop on a full queue
      u_if.dev_wr = 1'b1; u_if.dev_wdata = 16'h01FF; u_if.pop = 1'b1;
      cyc();
      idle();
      chk("fullrw_full", 32'(u_if.tx_full),   32'd1);
      chk("fullrw_err",  32'(u_if.err_flags), 32'b0001);
      exp_q = '{16'h0101, 16'h0102, 16'h0103, 16'h0104, 16'h0105, 16'h0106, 16'h0107, 16'h01FF};
      while (exp_q.size() > 0) begin
         v = exp_q.pop_front();
         chk("fullrw_order", 32'(u_if.D_pop), 32'(v));
         u_if.pop = 1'b1; cyc(); u_if.pop = 1'b0;
      end
      chk("fullrw_empty", 32'(u_if.pndng), 32'd0);

      // pop on empty TX
      u_if.pop = 1'b1; cyc(); idle();
      chk("txudf_err",   32'(u_if.err_flags), 32'b0011);
      chk("txudf_pndng", 32'(u_if.pndng),     32'd0);
      // dev_rd on empty RX with a same-cycle push
      u_if.dev_rd = 1'b1; u_if.push = 1'b1; u_if.D_push = 16'hBEEF;
      cyc(); idle();
      chk("rxudf_err",   32'(u_if.err_flags), 32'b1011);
      chk("rxudf_valid", 32'(u_if.rx_valid),  32'd1);
      chk("rxudf_data",  32'(u_if.dev_rdata), 32'h0000BEEF);
      u_if.dev_rd = 1'b1; cyc(); idle();
      chk("rx_drain", 32'(u_if.rx_valid), 32'd0);

      // fill RX, then 260 pushes into the full queue
      for (int i = 0; i < 8; i++) begin
         u_if.push = 1'b1; u_if.D_push = 16'h2000 + 16'(i); cyc();
      end
      chk("rx_full8", 32'(u_if.rx_full), 32'd1);
      chk("rx_nodrop", 32'(u_if.rx_drop_cnt), 32'd0);
      for (int i = 0; i < 260; i++) begin
         u_if.push = 1'b1; u_if.D_push = 16'h3000 + 16'(i); cyc();
         if (i == 2) chk("drop_3", 32'(u_if.rx_drop_cnt), 32'd3);
         if (i == 254) chk("drop_255", 32'(u_if.rx_drop_cnt), 32'd255);
      end
      idle();
      chk("drop_sat",  32'(u_if.rx_drop_cnt), 32'd255);
      chk("drop_err",  32'(u_if.err_flags),   32'b1111);
      chk("drop_head", 32'(u_if.dev_rdata),   32'h2000);

      // independent traffic, then reset mid-flight
      do_reset();
      chk_empty("rst2");
      for (int i = 0; i < 5; i++) begin
         u_if.dev_wr = (i < 4); u_if.dev_wdata = 16'h4000 + 16'(i);
         u_if.push = 1'b1;      u_if.D_push    = 16'h5000 + 16'(i);
         cyc();
      end
      idle();
      chk("mid_dpop",  32'(u_if.D_pop),     32'h4000);
      chk("mid_rdata", 32'(u_if.dev_rdata), 32'h5000);
      u_if.pop = 1'b1; u_if.push = 1'b1; u_if.D_push = 16'h5005;
      cyc(); idle();
      chk("indep_dpop",  32'(u_if.D_pop),     32'h4001);
      chk("indep_rdata", 32'(u_if.dev_rdata), 32'h5000);
      chk("indep_err",   32'(u_if.err_flags), 32'd0);
      u_if.pop = 1'b1; cyc(); idle();   // TX now 2, RX 6
      reset = 1'b0;
      u_if.dev_wr = 1'b1; u_if.dev_wdata = 16'hEEEE;
      u_if.push = 1'b1;   u_if.D_push = 16'hEEEE;
      cyc();
      idle();
      chk_empty("midrst");
      reset = 1'b1;
      u_if.dev_wr = 1'b1; u_if.dev_wdata = 16'hC001;
      u_if.push = 1'b1;   u_if.D_push = 16'hD001;
      cyc(); idle();
      chk("post_dpop",  32'(u_if.D_pop),     32'hC001);
      chk("post_rdata", 32'(u_if.dev_rdata), 32'hD001);
      u_if.pop = 1'b1; u_if.dev_rd = 1'b1; cyc(); idle();
      chk("post_pndng", 32'(u_if.pndng),    32'd0);
      chk("post_rxv",   32'(u_if.rx_valid), 32'd0);
      chk("post_err",   32'(u_if.err_flags), 32'd0);

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end
endmodule

// File: doc/bus_port_fifo.md
BUS_PORT_FIFO -- requirements
Module: bus_port_fifo

Interface
REQ-001 SHALL have parameter WIDTH, default 16: packet width in bits.
REQ-002 SHALL have parameter DEPTH, default 8: entries per queue; power of two, minimum 2.
REQ-003 SHALL have port clk, input, 1: single clock; all logic on rising edge.
REQ-004 SHALL have port reset, input, 1: one clock; reset is synchronous and active-low.
REQ-005 SHALL have port dev_wr, input, 1: device write strobe into the TX queue.
REQ-006 SHALL have port dev_wdata, input, WIDTH: device write data.
REQ-007 SHALL have port tx_full, output, 1: TX queue holds DEPTH entries.
REQ-008 SHALL have port pndng, output, 1: TX queue not empty; goes to the bus arbiter.
REQ-009 SHALL have port D_pop, output, WIDTH: TX head entry, show-ahead; goes to the bus arbiter.
REQ-010 SHALL have port pop, input, 1: bus arbiter consumes the TX head.
REQ-011 SHALL have port push, input, 1: bus arbiter delivers a packet into the RX queue.
REQ-012 SHALL have port D_push, input, WIDTH: delivered packet.
REQ-013 SHALL have port rx_valid, output, 1: RX queue not empty.
REQ-014 SHALL have port dev_rdata, output, WIDTH: RX head entry, show-ahead.
REQ-015 SHALL have port dev_rd, input, 1: device consumes the RX head.
REQ-016 SHALL have port rx_full, output, 1: RX queue holds DEPTH entries.
REQ-017 SHALL have port err_flags, output, 4: sticky flags {rx_udf, rx_ovf, tx_udf, tx_ovf}, MSB first.
REQ-018 SHALL have port rx_drop_cnt, output, 8: count of dropped RX packets.

Function
REQ-019 Each queue SHALL be a FIFO with an occupancy count of clog2(DEPTH)+1 bits and read/write pointers that wrap modulo DEPTH.
REQ-020 A write accepted at edge N SHALL be visible at the head (pndng or rx_valid high, data valid) in the cycle after edge N; there is no bypass.
REQ-021 A pop or dev_rd at edge N SHALL advance the head, with the next entry presented after edge N.
REQ-022 A write to a full queue with no same-cycle read SHALL drop the data, leave the queue unchanged and set the matching ovf flag.
REQ-023 A write and a read in the same cycle on a full queue SHALL both be accepted; occupancy stays DEPTH.
REQ-024 A read on an empty queue SHALL be ignored and set the matching udf flag; a same-cycle write to that empty queue SHALL still be accepted.
REQ-025 A write and a read in the same cycle on a non-empty, non-full queue SHALL leave occupancy unchanged.
REQ-026 rx_drop_cnt SHALL increment on every RX overflow drop and saturate at 255.
REQ-027 Data outputs SHALL present the entry at the read pointer; when the queue is empty they SHALL be 0.
REQ-028 Error flags SHALL remain set until reset.
REQ-029 The TX and RX queues SHALL be fully independent; simultaneous activity on both SHALL have no interaction.

Reset
REQ-030 While reset = 0 at a rising edge, all pointers, counts, err_flags and rx_drop_cnt SHALL clear to 0 at that edge.
REQ-031 After reset, outputs SHALL be: pndng=0, rx_valid=0, tx_full=0, rx_full=0, D_pop=0, dev_rdata=0.
REQ-032 Reset SHALL take priority over any same-cycle write or read; in-flight contents are discarded.
REQ-033 Storage arrays need not be cleared by reset.

Structure
REQ-034 Package bus_pkg SHALL hold the default WIDTH and DEPTH values, the DROP_CNT_W=8 constant and the err_flags bit-index constants.
REQ-035 A single sub-module, bus_sync_fifo (show-ahead, full/empty, ovf/udf pulse outputs), SHALL be instantiated twice: once for TX, once for RX.
REQ-036 Target size is 120-400 lines of RTL in total.

Verification
REQ-037 Reset then 3 dev_wr (0x0A01, 0x0A02, 0x0A03) -> pndng high one cycle after the first write; D_pop=0x0A01; 3 pops return 0x0A01, 0x0A02, 0x0A03 in order, then pndng=0.
REQ-038 9 writes with DEPTH=8 and no pops -> tx_full after the 8th write; the 9th write is dropped; err_flags[0]=1; D_pop still equals the first entry.
REQ-039 TX full, dev_wr and pop in the same cycle -> both accepted; tx_full stays 1; err_flags[0] unchanged.
REQ-040 pop on empty TX; separately dev_rd on empty RX -> err_flags[1]=1 and err_flags[3]=1; no state change; a same-cycle push into empty RX is accepted.
REQ-041 260 pushes into full RX with no reads -> rx_drop_cnt saturates at 255; err_flags[2]=1.
REQ-042 reset driven low mid-traffic (TX holding 4, RX holding 5) -> all outputs zero the next cycle; traffic after release starts from empty queues.
